// File: rtl/mux_share_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin channel arbiter.
//   state_t      : arbiter FSM states (idle, granted to 0, granted to 1)
//   DEFAULT_*    : default data width and burst limit
//   grant_state  : maps a requester index onto its GRANT state
package mux_share_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  localparam int DEFAULT_W         = 8;
  localparam int DEFAULT_MAX_BURST = 4;

  function automatic state_t grant_state(input logic idx);
    return idx ? ST_G1 : ST_G0;
  endfunction

endpackage

// File: rtl/mux_share_arbiter_mux2x1.sv
// Single-bit 2:1 multiplexer cell used to build the shared datapath.
//   s : select (0 picks i[0], 1 picks i[1])
//   i : the two candidate bits, {in1, in0}
//   y : selected bit
module mux2x1 (
  input  logic       s,
  input  logic [1:0] i,
  output logic       y
);

  assign y = s ? i[1] : i[0];

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter that shares one W-bit valid/ready channel between two
// requesters, with a burst limit that only applies while both are asking.
//   clk, rst           : clock (rising edge), asynchronous active-high reset
//   req0/data0, ack0   : requester 0 beat request, its data, its accept pulse
//   req1/data1, ack1   : requester 1 beat request, its data, its accept pulse
//   out_valid/out_data : shared channel beat, data = sel ? data1 : data0
//   out_ready          : downstream accept
//   sel                : registered grant owner / mux select
//   busy               : arbiter is not idle
module mux_share_arbiter
  import mux_share_arbiter_pkg::*;
#(
  parameter int W         = DEFAULT_W,
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [W-1:0] data0,
  input  logic         req1,
  input  logic [W-1:0] data1,
  output logic         ack0,
  output logic         ack1,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  output logic         sel,
  output logic         busy
);

  localparam int            CW       = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

  state_t        state;
  state_t        state_next;
  logic          last;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;

  // Owner/other view of the requests so GRANT0 and GRANT1 share one decode.
  logic owner;
  logic owner_req;
  logic other_req;

  assign owner     = (state == ST_G1);
  assign owner_req = owner ? req1 : req0;
  assign other_req = owner ? req0 : req1;

  assign out_valid = ((state == ST_G0) && req0) || ((state == ST_G1) && req1);
  assign ack0      = out_valid && out_ready && (state == ST_G0);
  assign ack1      = out_valid && out_ready && (state == ST_G1);
  assign busy      = (state != ST_IDLE);

  // In a GRANT state the owner's request is high whenever a beat is offered,
  // so an accepted beat is simply owner_req && out_ready. A stalled beat
  // (out_ready low) holds both state and count, so the grant never moves
  // under a beat the downstream has not taken yet.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (req0 && req1) begin
          state_next = grant_state(!last);
        end else if (req0) begin
          state_next = ST_G0;
        end else if (req1) begin
          state_next = ST_G1;
        end
      end
      ST_G0, ST_G1: begin
        if (!owner_req) begin
          state_next = other_req ? grant_state(!owner) : ST_IDLE;
          cnt_next   = '0;
        end else if (out_ready) begin
          if (cnt == CNT_LAST) begin
            // Burst limit only forces a hand-over when the other side waits.
            cnt_next = '0;
            if (other_req) begin
              state_next = grant_state(!owner);
            end
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // last starts at 1 so the first tie after reset goes to requester 0.
  // sel and last both follow the grant; IDLE leaves them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      sel   <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state_next != ST_IDLE) begin
        sel  <= (state_next == ST_G1);
        last <= (state_next == ST_G1);
      end
    end
  end

  for (genvar k = 0; k < W; k++) begin : g_mux
    mux2x1 u_mux (
      .s (sel),
      .i ({data1[k], data0[k]}),
      .y (out_data[k])
    );
  end

endmodule

// File: tb/tb_mux_share_arbiter.sv
// Self-checking bench for mux_share_arbiter: a MAX_BURST=4 instance driven
// from a vector table plus hand-written reset/backpressure sequences, and a
// MAX_BURST=1 instance sharing the same inputs for the alternation case.
module tb_mux_share_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0;
  logic         req1 = 1'b0;
  logic [W-1:0] data0 = '0;
  logic [W-1:0] data1 = '0;
  logic         out_ready = 1'b0;

  logic         ack0, ack1, out_valid, sel, busy;
  logic [W-1:0] out_data;
  logic         b_ack0, b_ack1, b_out_valid, b_sel, b_busy;
  logic [W-1:0] b_out_data;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mux_share_arbiter #(.W(W), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .ack0      (ack0),
    .ack1      (ack1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy)
  );

  mux_share_arbiter #(.W(W), .MAX_BURST(1)) dut_b1 (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .ack0      (b_ack0),
    .ack1      (b_ack1),
    .out_valid (b_out_valid),
    .out_data  (b_out_data),
    .out_ready (out_ready),
    .sel       (b_sel),
    .busy      (b_busy)
  );

  // Observed outputs packed as {valid, ack0, ack1, sel, busy, data}.
  logic [12:0] obs;
  logic [12:0] b_obs;
  assign obs   = {out_valid, ack0, ack1, sel, busy, out_data};
  assign b_obs = {b_out_valid, b_ack0, b_ack1, b_sel, b_busy, b_out_data};

  typedef struct {
    logic         rst_before;
    logic         req0;
    logic         req1;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic         ready;
    logic [12:0]  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [12:0] pk(input logic v, input logic a0, input logic a1,
                                     input logic s, input logic b, input logic [W-1:0] d);
    return {v, a0, a1, s, b, d};
  endfunction

  task automatic add(input logic rb, input logic r0, input logic r1, input logic [W-1:0] d0,
                     input logic [W-1:0] d1, input logic rdy, input logic [12:0] e);
    vec_t v;
    v.rst_before = rb;
    v.req0       = r0;
    v.req1       = r1;
    v.data0      = d0;
    v.data1      = d1;
    v.ready      = rdy;
    v.exp        = e;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r0, input logic r1, input logic [W-1:0] d0,
                               input logic [W-1:0] d1, input logic rdy);
    @(posedge clk);
    #1;
    req0      = r0;
    req1      = r1;
    data0     = d0;
    data1     = d1;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp)
      $display("[TB] FAIL %s: got {v,a0,a1,sel,busy,data}=%b_%h required %b_%h",
               name, act[12:8], act[7:0], exp[12:8], exp[7:0]);
    else
      passed++;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req0      = 1'b0;
    req1      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    // Single requester: six back-to-back beats, never switched, then idle.
    add(1, 1, 0, 8'hA5, 8'h00, 1, pk(0, 0, 0, 0, 0, 8'hA5));
    for (int i = 0; i < 6; i++)
      add(0, 1, 0, 8'hA5, 8'h00, 1, pk(1, 1, 0, 0, 1, 8'hA5));
    add(0, 0, 0, 8'hA5, 8'h00, 1, pk(0, 0, 0, 0, 1, 8'hA5));
    add(0, 0, 0, 8'hA5, 8'h00, 1, pk(0, 0, 0, 0, 0, 8'hA5));
    // Contention from reset: 0 first, four beats each, no gap between owners.
    add(1, 1, 1, 8'h11, 8'h22, 1, pk(0, 0, 0, 0, 0, 8'h11));
    for (int i = 0; i < 4; i++)
      add(0, 1, 1, 8'h11, 8'h22, 1, pk(1, 1, 0, 0, 1, 8'h11));
    for (int i = 0; i < 4; i++)
      add(0, 1, 1, 8'h11, 8'h22, 1, pk(1, 0, 1, 1, 1, 8'h22));
    add(0, 1, 1, 8'h11, 8'h22, 1, pk(1, 1, 0, 0, 1, 8'h11));
    // Early drop hands over to 1; later tie from IDLE goes to 0, sel kept in IDLE.
    add(1, 1, 0, 8'h55, 8'h66, 1, pk(0, 0, 0, 0, 0, 8'h55));
    add(0, 1, 0, 8'h55, 8'h66, 1, pk(1, 1, 0, 0, 1, 8'h55));
    add(0, 0, 1, 8'h55, 8'h66, 1, pk(0, 0, 0, 0, 1, 8'h55));
    add(0, 0, 1, 8'h55, 8'h66, 1, pk(1, 0, 1, 1, 1, 8'h66));
    add(0, 0, 0, 8'h55, 8'h66, 1, pk(0, 0, 0, 1, 1, 8'h66));
    add(0, 1, 1, 8'h55, 8'h66, 1, pk(0, 0, 0, 1, 0, 8'h66));
    add(0, 1, 1, 8'h55, 8'h66, 1, pk(1, 1, 0, 0, 1, 8'h55));

    // Reset state, then an asynchronous reset landing mid-cycle on a live grant.
    data0 = 8'h10;
    data1 = 8'h9E;
    @(negedge clk);
    checkOutput("reset_state", obs, pk(0, 0, 0, 0, 0, 8'h10));
    rst       = 1'b0;
    req1      = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("pre_async_grant1", obs, pk(1, 0, 1, 1, 1, 8'h9E));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_immediate", obs, pk(0, 0, 0, 0, 0, 8'h10));
    @(negedge clk);
    rst  = 1'b0;
    req1 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_after_release", obs, pk(0, 0, 0, 0, 0, 8'h10));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst_before) do_reset();
      applyStimulus(vecs[i].req0, vecs[i].req1, vecs[i].data0, vecs[i].data1, vecs[i].ready);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Backpressure in GRANT1 at cnt=2 with req0 waiting: held five cycles,
    // then two more beats complete the burst of four before handing over.
    do_reset();
    applyStimulus(0, 1, 8'h77, 8'h3C, 1);
    @(negedge clk);
    checkOutput("bp_idle", obs, pk(0, 0, 0, 0, 0, 8'h77));
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 8'h77, 8'h3C, 1);
      @(negedge clk);
      checkOutput($sformatf("bp_beat%0d", i), obs, pk(1, 0, 1, 1, 1, 8'h3C));
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 8'h77, 8'h3C, 0);
      @(negedge clk);
      checkOutput($sformatf("bp_stall%0d", i), obs, pk(1, 0, 0, 1, 1, 8'h3C));
    end
    for (int i = 2; i < 4; i++) begin
      applyStimulus(1, 1, 8'h77, 8'h3C, 1);
      @(negedge clk);
      checkOutput($sformatf("bp_beat%0d", i), obs, pk(1, 0, 1, 1, 1, 8'h3C));
    end
    applyStimulus(1, 1, 8'h77, 8'h3C, 1);
    @(negedge clk);
    checkOutput("bp_handover", obs, pk(1, 1, 0, 0, 1, 8'h77));

    // MAX_BURST=1 instance alternates owners on every beat.
    do_reset();
    applyStimulus(1, 1, 8'h0F, 8'hF0, 1);
    @(negedge clk);
    checkOutput("b1_idle", b_obs, pk(0, 0, 0, 0, 0, 8'h0F));
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, 1, 8'h0F, 8'hF0, 1);
      @(negedge clk);
      if (i % 2 == 1)
        checkOutput($sformatf("b1_beat%0d", i), b_obs, pk(1, 1, 0, 0, 1, 8'h0F));
      else
        checkOutput($sformatf("b1_beat%0d", i), b_obs, pk(1, 0, 1, 1, 1, 8'hF0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
